// File: rtl/gpio_bus_arb.sv
// Round-robin arbiter sharing the gpio slave bus among four requesters.
// Optional WAIT timeout: define GPIO_BUS_ARB_TIMEOUT_EN.
module gpio_bus_arb #(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          m_req,
  input  logic [3:0]          m_rw,
  input  logic [4*ADDR_W-1:0] m_addr,
  input  logic [127:0]        m_wr_data,
  output logic [3:0]          m_grnt,
  output logic [3:0]          m_done,
  output logic                m_err,
  output logic [31:0]         m_rd_data,
  output logic                busy,
  output logic                cs_,
  output logic                as_,
  output logic                rw,
  output logic [ADDR_W-1:0]   addr,
  output logic [31:0]         wr_data,
  input  logic [31:0]         rd_data,
  input  logic                rdy_
);

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_WAIT
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] own;
  logic [1:0] pick;

  // Lowest offset from the pointer wins, so scan offsets high to low.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] p
  );
    logic [1:0] r;
    logic [1:0] i;
    r = p;
    for (int k = 3; k >= 0; k--) begin
      i = p + 2'(k);
      if (req[i]) r = i;
    end
    return r;
  endfunction

  assign pick = rr_pick(m_req, ptr);
  assign busy = (state != S_IDLE);

`ifdef GPIO_BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);
  logic [7:0] wcnt;
  logic       err_q;
  assign m_err = err_q;
`else
  assign m_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      own       <= '0;
      m_grnt    <= '0;
      m_done    <= '0;
      m_rd_data <= '0;
      cs_       <= DISABLE_;
      as_       <= DISABLE_;
      rw        <= READ;
      addr      <= '0;
      wr_data   <= '0;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
      wcnt      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      m_done <= '0;
      unique case (state)
        S_IDLE: begin
          if (|m_req) begin
            own     <= pick;
            m_grnt  <= 4'b0001 << pick;
            rw      <= m_rw[pick];
            addr    <= m_addr[int'(pick)*ADDR_W +: ADDR_W];
            wr_data <= m_wr_data[int'(pick)*32 +: 32];
            cs_     <= ENABLE_;
            as_     <= ENABLE_;
            state   <= S_BUS;
          end
        end
        S_BUS: begin
          cs_   <= DISABLE_;
          as_   <= DISABLE_;
          state <= S_WAIT;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (!rdy_) begin
            m_done    <= m_grnt;
            m_grnt    <= '0;
            m_rd_data <= (rw == WRITE) ? '0 : rd_data;
            ptr       <= own + 2'd1;
            state     <= S_IDLE;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
          else if (wcnt == WLAST) begin
            m_done    <= m_grnt;
            m_grnt    <= '0;
            m_rd_data <= '0;
            ptr       <= own + 2'd1;
            state     <= S_IDLE;
            err_q     <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Bench for gpio_bus_arb: gpio slave stand-in, timeline reference model,
// directed scenarios and a randomized phase.
module tb_gpio_bus_arb;

  localparam int   TO    = 4;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   m_req = '0;
  logic [3:0]   m_rw = '1;
  logic [7:0]   m_addr = '0;
  logic [127:0] m_wr_data = '0;
  logic [3:0]   m_grnt;
  logic [3:0]   m_done;
  logic         m_err;
  logic [31:0]  m_rd_data;
  logic         busy;
  logic         cs_;
  logic         as_;
  logic         rw;
  logic [1:0]   addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data = '0;
  logic         rdy_ = 1'b1;

  gpio_bus_arb #(.ADDR_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_grnt(m_grnt), .m_done(m_done),
    .m_err(m_err), .m_rd_data(m_rd_data), .busy(busy),
    .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // gpio stand-in: reg 0 is IN_DATA (reads gpio_in), reg 1 is OUT_DATA
  logic [31:0] gpio_in = 32'hA;
  logic [31:0] sreg[4] = '{default: 0};
  int          slat = 1;
  bit          stall = 0;
  bit          s_pend = 0;
  int          s_left = 0;
  logic [31:0] s_rd = '0;

  always @(posedge clk) begin
    if (!cs_ && !as_) begin
      if (rw == WRITE) begin
        if (addr != 2'd0) sreg[addr] = wr_data;
        s_rd = $urandom;
      end else begin
        s_rd = (addr == 2'd0) ? gpio_in : sreg[addr];
      end
      s_pend = 1;
      s_left = slat - 1;
    end
    if (reset) s_pend = 0;
    rdy_ <= 1'b1;
    if (s_pend && !stall) begin
      if (s_left == 0) begin
        rdy_    <= 1'b0;
        rd_data <= s_rd;
        s_pend  = 0;
      end else begin
        s_left--;
      end
    end
  end

  // Reference model: a transaction granted at edge e with slave latency L
  // owns slots e..e+L, strobes in slot e, completes in slot e+L+1.
  int          cyc = 0;
  int          free_edge = 0;
  int          mptr = 0;
  bit          g_act = 0;
  int          g_edge = 0;
  int          g_lat = 1;
  int          g_own = 0;
  logic        g_rw = 1'b1;
  logic [1:0]  g_addr = '0;
  logic [31:0] g_wd = '0;
  logic [31:0] g_rd = '0;
  logic [31:0] exp_rd = '0;
  logic [31:0] mem[4] = '{default: 0};
  bit          rand_lat = 0;
  bit          mchk = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      g_act = 0;
      mptr = 0;
      exp_rd = '0;
      free_edge = cyc + 1;
    end else if (cyc >= free_edge) begin
      if (|m_req) begin
        bit found;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (mptr + k) % 4;
          if (!found && m_req[idx]) begin
            g_own = idx;
            found = 1;
          end
        end
        if (rand_lat) slat = $urandom_range(1, 3);
        g_act  = 1;
        g_edge = cyc;
        g_lat  = slat;
        g_rw   = m_rw[g_own];
        g_addr = m_addr[g_own*2 +: 2];
        g_wd   = m_wr_data[g_own*32 +: 32];
        if (g_rw == WRITE) begin
          if (g_addr != 2'd0) mem[g_addr] = g_wd;
          g_rd = '0;
        end else begin
          g_rd = (g_addr == 2'd0) ? gpio_in : mem[g_addr];
        end
        mptr = (g_own + 1) % 4;
        free_edge = cyc + 2 + g_lat;
      end else begin
        free_edge = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      bit in_win;
      bit is_done;
      logic [3:0] oh;
      oh = 4'b0001 << g_own;
      in_win = g_act && cyc >= g_edge && cyc <= g_edge + g_lat;
      is_done = g_act && cyc == g_edge + g_lat + 1;
      if (is_done) exp_rd = g_rd;
      check("grnt", m_grnt, in_win ? oh : 4'b0);
      check("busy", busy, in_win);
      check("cs_", cs_, !(g_act && cyc == g_edge));
      check("as_", as_, !(g_act && cyc == g_edge));
      check("done", m_done, is_done ? oh : 4'b0);
      check("rd_data", m_rd_data, exp_rd);
      check("err", m_err, 1'b0);
      if (g_act && cyc == g_edge) begin
        check("bus_addr", addr, g_addr);
        check("bus_rw", rw, g_rw);
        if (g_rw == WRITE) check("bus_wdata", wr_data, g_wd);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_cmd(input int i, input logic r, input logic [1:0] a,
                         input logic [31:0] d);
    m_rw[i] = r;
    m_addr[i*2 +: 2] = a;
    m_wr_data[i*32 +: 32] = d;
  endtask

  initial begin
    int cnt;
    bit seen;
    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mchk = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_rw", rw, READ);
      check("rst_addr", addr, 2'd0);
      check("rst_wdata", wr_data, 32'd0);
    end

    // requester 1 reads IN_DATA
    set_cmd(1, READ, 2'd0, 32'd0);
    m_req = 4'b0010;
    @(negedge clk);
    check("rd1_cs", cs_, 1'b0);
    check("rd1_as", as_, 1'b0);
    check("rd1_addr", addr, 2'd0);
    m_req = 4'b0000;
    @(negedge clk);
    check("rd1_cs_one", cs_, 1'b1);
    @(negedge clk);
    check("rd1_done", m_done, 4'b0010);
    check("rd1_data", m_rd_data, 32'hA);
    @(negedge clk);

    // four requesters write OUT_DATA, round-robin order
    do_reset();
    for (int i = 0; i < 4; i++) set_cmd(i, WRITE, 2'd1, 32'h10 + i);
    m_req = 4'hF;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("rr_order", m_grnt, 4'b0001 << (k % 4));
      if (k == 3) m_rw[0] = READ;
      if (k == 4) m_req = 4'h0;
      repeat (3) @(negedge clk);
    end
    check("out_readback", m_rd_data, 32'h13);

    // requester 2 drops its request in the grant cycle
    set_cmd(2, WRITE, 2'd1, 32'h56);
    m_req = 4'b0100;
    @(negedge clk);
    m_req = 4'b0000;
    set_cmd(2, READ, 2'd2, $urandom);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_done[2]) cnt++;
    end
    check("drop_done_cnt", cnt, 1);
    set_cmd(2, READ, 2'd1, 32'd0);
    m_req = 4'b0100;
    @(negedge clk);
    m_req = 4'b0000;
    repeat (2) @(negedge clk);
    check("drop_rd_done", m_done, 4'b0100);
    check("drop_rd_data", m_rd_data, 32'h56);
    @(negedge clk);

    // reset during WAIT aborts and clears the pointer
    slat = 2;
    m_req = 4'b0100;
    @(negedge clk);
    m_req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_done", m_done, 4'b0);
    check("abort_cs", cs_, 1'b1);
    check("abort_as", as_, 1'b1);
    check("abort_grnt", m_grnt, 4'b0);
    slat = 1;
    m_req = 4'hF;
    @(negedge clk);
    check("abort_ptr", m_grnt, 4'b0001);
    m_req = 4'h0;
    repeat (4) @(negedge clk);

    // slave never answers
    mchk = 0;
    stall = 1;
    set_cmd(3, READ, 2'd2, 32'd0);
    m_req = 4'b1000;
    @(negedge clk);
    m_req = 4'b0000;
`ifdef GPIO_BUS_ARB_TIMEOUT_EN
    repeat (TO) @(negedge clk);
    check("to_early", m_done, 4'b0);
    @(negedge clk);
    check("to_done", m_done, 4'b1000);
    check("to_err", m_err, 1'b1);
    check("to_data", m_rd_data, 32'd0);
`else
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_done != 4'b0) cnt++;
    end
    check("stall_no_done", cnt, 0);
    check("stall_busy", busy, 1'b1);
    stall = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (m_done != 4'b0) begin
        seen = 1;
        check("stall_done", m_done, 4'b1000);
        check("stall_err", m_err, 1'b0);
      end
    end
    check("stall_release_seen", seen, 1'b1);
`endif
    do_reset();
    stall = 0;
    mchk = 1;

    // randomized traffic
    rand_lat = 1;
    gpio_in = $urandom;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      m_req = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      m_rw = 4'($urandom);
      m_addr = 8'($urandom);
      m_wr_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    reset = 1'b0;
    m_req = 4'h0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
